fpnew_round_arbiter: RTL
========================

Name: fpnew_round_arbiter

Overview:
- Shares one rounding datapath (fpnew_rounding, width AbsWidth) among NumReq pre-rounding producers, e.g. ADD, MUL and CAST lanes.
- Arbitration is round-robin. Each request is a valid/ready transaction carrying abs value, sign, RS bits, rounding mode, effective-subtraction flag and op.
- The rounded result is registered once and returned on a single valid/ready output with the winner index and a caller tag.
- Sits between the lane normalisers and the final result packing stage.

Parameters:
- NumReq, 3, number of requesters (2..8).
- AbsWidth, 32, width of the absolute value without sign.
- TagWidth, 4, opaque caller tag width carried through.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous kill of the held result.
- req_valid_i  in  NumReq  per-requester valid.
- req_ready_o  out  NumReq  per-requester ready (grant).
- req_abs_i  in  NumReq*AbsWidth  absolute values, requester i at bits [i*AbsWidth +: AbsWidth].
- req_sign_i  in  NumReq  signs.
- req_rs_i  in  NumReq*2  round/sticky bits {R,S}.
- req_rm_i  in  NumReq*3  rounding modes (fpnew_pkg::roundmode_e encoding).
- req_effsub_i  in  NumReq  effective-subtraction flags.
- req_op_i  in  NumReq*fpnew_pkg::OP_BITS  operation.
- req_tag_i  in  NumReq*TagWidth  caller tags.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer ready.
- out_abs_o  out  AbsWidth  rounded absolute value.
- out_sign_o  out  1  result sign.
- out_exact_zero_o  out  1  exact-zero flag.
- out_rm_illegal_o  out  1  request carried rm 5..7.
- out_src_o  out  $clog2(NumReq)  index of the winning requester.
- out_tag_o  out  TagWidth  tag of the winning request.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - out_valid_o=0.
  - Round-robin pointer ptr=0.
  - All output data registers 0; req_ready_o=0.
  - Optional counters 0.
- Output stage:
  - One register stage. accept = !out_valid_o || out_ready_i.
  - A handshake on requester i in cycle N gives out_valid_o=1 in cycle N+1. Latency is exactly 1 cycle.
- Arbitration (combinational):
  - Search req_valid_i from index ptr upward, wrapping modulo NumReq. The first set bit is the winner g.
  - req_ready_o[g]=accept; all other bits of req_ready_o are 0.
  - req_ready_o does not depend on req_valid_i of non-winners.
  - If no valid, req_ready_o=0.
- Pointer update:
  - Only on a handshake: ptr <= (g==NumReq-1) ? 0 : g+1.
  - No handshake leaves ptr unchanged.
- Datapath:
  - The winner's fields are muxed into the rounding cell.
  - Its outputs, plus g, the tag and the illegal-rm flag, are captured on handshake.
  - out_rm_illegal_o=1 when rm is 5..7. In that case RTZ is substituted, so the result is abs unchanged.
- Hold:
  - While out_valid_o=1 and out_ready_i=0, all out_* stay stable.
  - No request is granted while holding.
- Back-to-back:
  - out_valid_o=1 with out_ready_i=1 and a valid request: new result loaded, out_valid_o stays 1. Full throughput, one result per cycle.
  - out_ready_i=1 with no request: out_valid_o goes to 0 next cycle.
- Flush:
  - flush_i=1 clears out_valid_o next cycle and forces req_ready_o=0 that cycle.
  - ptr is unchanged.
  - flush_i has priority over load and hold.
- Rounding arithmetic:
  - abs+round_up wraps silently at all-ones; overflow to infinity is the caller's encoding concern.
  - Zero sign rule: an exact zero under effective subtraction gives sign 1 only for RDN with op≠MUL.
- Reset mid-transfer: any held result is discarded and no partial grant survives.
- Fairness: a requester holding valid high is granted within NumReq handshakes.

Optional Feature:
- Macro FPNEW_RND_ARB_STATS_EN.
- Defined:
  - Adds output stat_grants_o [NumReq*16], one 16-bit saturating grant counter per requester, incremented on that requester's handshake.
  - Adds output stat_stall_o [16], a saturating count of cycles with out_valid_o=1 and out_ready_i=0.
  - Counters reset to 0 asynchronously and are not affected by flush_i.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
- Single request, RNE: req0 abs=0x0000_0005, RS=2'b10, sign=0, tag=3, out_ready_i=1 → next cycle out_valid_o=1, abs=0x6, src=0, tag=3, exact_zero=0.
- All three valid continuously, out_ready_i=1 → grant order 0,1,2,0,1,2. out_src_o follows the same order one cycle later, one result per cycle.
- Back-pressure: result held with out_ready_i=0 for 4 cycles while req1 valid → out_* stable and req_ready_o=0 throughout. Release → req1 result appears on the following cycle.
- Zero sign: abs=0, RS=00, effsub=1, rm=RDN, op=ADD, sign=0 → out_sign_o=1, exact_zero=1. Same with op=MUL → out_sign_o=0.
- Illegal rm: rm=3'b101, abs=0x7, RS=11 → abs=0x7, out_rm_illegal_o=1. flush_i during the hold → out_valid_o=0 next cycle and ptr is unchanged.
- Async reset asserted mid-stream with valid held → out_valid_o=0 immediately. After release, the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/fpnew_round_arbiter_if.sv
// Request/result bundle for the shared rounding arbiter.
// master drives requests and out_ready; slave is the arbiter.
interface fpnew_round_arbiter_if #(
  parameter int unsigned NumReq   = 3,
  parameter int unsigned AbsWidth = 32,
  parameter int unsigned TagWidth = 4,
  parameter int unsigned OpBits   = 4
);
  localparam int unsigned SrcW = $clog2(NumReq);

  logic [NumReq-1:0]          req_valid_i;
  logic [NumReq-1:0]          req_ready_o;
  logic [NumReq*AbsWidth-1:0] req_abs_i;
  logic [NumReq-1:0]          req_sign_i;
  logic [NumReq*2-1:0]        req_rs_i;
  logic [NumReq*3-1:0]        req_rm_i;
  logic [NumReq-1:0]          req_effsub_i;
  logic [NumReq*OpBits-1:0]   req_op_i;
  logic [NumReq*TagWidth-1:0] req_tag_i;

  logic                out_valid_o;
  logic                out_ready_i;
  logic [AbsWidth-1:0] out_abs_o;
  logic                out_sign_o;
  logic                out_exact_zero_o;
  logic                out_rm_illegal_o;
  logic [SrcW-1:0]     out_src_o;
  logic [TagWidth-1:0] out_tag_o;

  modport master (
    output req_valid_i, req_abs_i, req_sign_i,
    output req_rs_i, req_rm_i, req_effsub_i,
    output req_op_i, req_tag_i, out_ready_i,
    input  req_ready_o, out_valid_o, out_abs_o,
    input  out_sign_o, out_exact_zero_o,
    input  out_rm_illegal_o, out_src_o, out_tag_o
  );

  modport slave (
    input  req_valid_i, req_abs_i, req_sign_i,
    input  req_rs_i, req_rm_i, req_effsub_i,
    input  req_op_i, req_tag_i, out_ready_i,
    output req_ready_o, out_valid_o, out_abs_o,
    output out_sign_o, out_exact_zero_o,
    output out_rm_illegal_o, out_src_o, out_tag_o
  );
endinterface

// File: rtl/fpnew_round_arbiter.sv
// Round-robin share of one rounding cell with a single output register.
// Optional FPNEW_RND_ARB_STATS_EN adds grant and stall counters.
module fpnew_round_arbiter #(
  parameter int unsigned NumReq   = 3,
  parameter int unsigned AbsWidth = 32,
  parameter int unsigned TagWidth = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  fpnew_round_arbiter_if.slave io
`ifdef FPNEW_RND_ARB_STATS_EN
  ,
  output logic [NumReq*16-1:0] stat_grants_o,
  output logic [15:0]          stat_stall_o
`endif
);
  localparam int unsigned OpBits = 4;
  localparam int unsigned SrcW   = $clog2(NumReq);
  localparam int          NR     = int'(NumReq);

  localparam logic [2:0] RmRne = 3'd0;
  localparam logic [2:0] RmRtz = 3'd1;
  localparam logic [2:0] RmRdn = 3'd2;
  localparam logic [2:0] RmRup = 3'd3;
  localparam logic [2:0] RmRmm = 3'd4;
  localparam logic [OpBits-1:0] OpMul = 4'd3;

  typedef logic [SrcW-1:0] src_t;

  src_t                ptr_q, ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [AbsWidth-1:0] out_abs_q, out_abs_d;
  logic                out_sign_q, out_sign_d;
  logic                out_zero_q, out_zero_d;
  logic                out_ill_q, out_ill_d;
  src_t                out_src_q, out_src_d;
  logic [TagWidth-1:0] out_tag_q, out_tag_d;

  logic              found;
  int                win_idx;
  src_t              win;
  logic              accept;
  logic              hs;
  logic [NumReq-1:0] req_ready;

  always_comb begin
    found   = 1'b0;
    win_idx = 0;
    for (int k = 0; k < NR; k++) begin
      if (!found && io.req_valid_i[(int'(ptr_q) + k) % NR]) begin
        found   = 1'b1;
        win_idx = (int'(ptr_q) + k) % NR;
      end
    end
  end

  assign win    = src_t'(win_idx);
  assign accept = !out_valid_q || io.out_ready_i;
  // rst_ni gating keeps every grant low while reset is held
  assign hs     = accept && !flush_i && found && rst_ni;

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[win_idx] = 1'b1;
  end

  logic [AbsWidth-1:0] abs_w;
  logic                sign_w;
  logic [1:0]          rs_w;
  logic [2:0]          rm_w;
  logic                effsub_w;
  logic [OpBits-1:0]   op_w;
  logic [TagWidth-1:0] tag_w;

  assign abs_w    = io.req_abs_i[win_idx*AbsWidth +: AbsWidth];
  assign sign_w   = io.req_sign_i[win_idx];
  assign rs_w     = io.req_rs_i[win_idx*2 +: 2];
  assign rm_w     = io.req_rm_i[win_idx*3 +: 3];
  assign effsub_w = io.req_effsub_i[win_idx];
  assign op_w     = io.req_op_i[win_idx*OpBits +: OpBits];
  assign tag_w    = io.req_tag_i[win_idx*TagWidth +: TagWidth];

  logic                rm_ill;
  logic [2:0]          rm_eff;
  logic                round_up;
  logic                exact_zero;
  logic                rnd_sign;
  logic [AbsWidth-1:0] rnd_abs;

  assign rm_ill = rm_w[2] & (|rm_w[1:0]);
  assign rm_eff = rm_ill ? RmRtz : rm_w;

  always_comb begin
    round_up = 1'b0;
    unique case (1'b1)
      (rm_eff == RmRne): round_up = rs_w[1] & (rs_w[0] | abs_w[0]);
      (rm_eff == RmRdn): round_up = (|rs_w) & sign_w;
      (rm_eff == RmRup): round_up = (|rs_w) & ~sign_w;
      (rm_eff == RmRmm): round_up = rs_w[1];
      default:           round_up = 1'b0;
    endcase
  end

  // wraps at all-ones; infinity encoding belongs to the caller
  assign rnd_abs    = abs_w + AbsWidth'(round_up);
  assign exact_zero = (abs_w == '0) && (rs_w == 2'b00);
  assign rnd_sign   = (exact_zero && effsub_w)
                    ? ((rm_eff == RmRdn) && (op_w != OpMul))
                    : sign_w;

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_abs_d   = out_abs_q;
    out_sign_d  = out_sign_q;
    out_zero_d  = out_zero_q;
    out_ill_d   = out_ill_q;
    out_src_d   = out_src_q;
    out_tag_d   = out_tag_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (hs) begin
      out_valid_d = 1'b1;
      out_abs_d   = rnd_abs;
      out_sign_d  = rnd_sign;
      out_zero_d  = exact_zero;
      out_ill_d   = rm_ill;
      out_src_d   = win;
      out_tag_d   = tag_w;
      ptr_d       = (win == src_t'(NumReq - 1)) ? '0 : win + src_t'(1);
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_abs_q   <= '0;
      out_sign_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      out_ill_q   <= 1'b0;
      out_src_q   <= '0;
      out_tag_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_abs_q   <= out_abs_d;
      out_sign_q  <= out_sign_d;
      out_zero_q  <= out_zero_d;
      out_ill_q   <= out_ill_d;
      out_src_q   <= out_src_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign io.req_ready_o      = req_ready;
  assign io.out_valid_o      = out_valid_q;
  assign io.out_abs_o        = out_abs_q;
  assign io.out_sign_o       = out_sign_q;
  assign io.out_exact_zero_o = out_zero_q;
  assign io.out_rm_illegal_o = out_ill_q;
  assign io.out_src_o        = out_src_q;
  assign io.out_tag_o        = out_tag_q;

`ifdef FPNEW_RND_ARB_STATS_EN
  logic [15:0] grants_q [NumReq];
  logic [15:0] grants_d [NumReq];
  logic [15:0] stall_q, stall_d;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      grants_d[i] = grants_q[i];
      if (hs && (win_idx == i) && (grants_q[i] != 16'hffff))
        grants_d[i] = grants_q[i] + 16'd1;
    end
    stall_d = stall_q;
    if (out_valid_q && !io.out_ready_i && (stall_q != 16'hffff))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR; i++) grants_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NR; i++) grants_q[i] <= grants_d[i];
      stall_q <= stall_d;
    end
  end

  for (genvar g = 0; g < NR; g++) begin : g_stat
    assign stat_grants_o[g*16 +: 16] = grants_q[g];
  end
  assign stat_stall_o = stall_q;
`endif
endmodule
